if_id_skid: RTL and testbench

//  Fetch-to-decode pipeline buffer. It captures {pc+2, instruction} from the fetch stage and presents them to decode.
//  Two-entry skid FIFO with a valid/ready handshake, so a decode stall never creates a combinational path back into fetch.

---
 rtl/if_id_skid.sv | 111 +++++++++++
 tb/tb_if_id_skid.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/if_id_skid.sv
// Fetch-to-decode buffer: two-entry skid FIFO (head e0, skid e1) with flush and HALT intake block.
// Every output is a register, so neither decode stalls nor fetch inputs reach the other side combinationally.
//
// state    | meaning
// ST_EMPTY | no entry held
// ST_ONE   | head entry e0 valid
// ST_FULL  | e0 and skid entry e1 valid; intake blocked
module if_id_skid #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] NOP_INSTR = 16'h0800
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_pc,
  input  logic [WIDTH-1:0] in_instr,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_pc,
  output logic [WIDTH-1:0] out_instr,
  output logic             halted
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t           state, state_n;
  logic             halted_n;
  logic             accept, pop, is_halt;
  logic [WIDTH-1:0] e0_pc, e0_instr, e1_pc, e1_instr;
  logic [WIDTH-1:0] e0_pc_n, e0_instr_n, e1_pc_n, e1_instr_n;

  assign accept  = in_valid & in_ready;
  assign pop     = out_valid & out_ready;
  assign is_halt = (in_instr[WIDTH-1 -: 5] == 5'b00000);

  always_comb begin
    state_n    = state;
    e0_pc_n    = e0_pc;
    e0_instr_n = e0_instr;
    e1_pc_n    = e1_pc;
    e1_instr_n = e1_instr;
    halted_n   = halted | (accept & is_halt);
    case (state)
      ST_EMPTY: begin
        if (accept) begin
          e0_pc_n    = in_pc;
          e0_instr_n = in_instr;
          state_n    = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && !pop) begin
          e1_pc_n    = in_pc;
          e1_instr_n = in_instr;
          state_n    = ST_FULL;
        end else if (accept && pop) begin
          e0_pc_n    = in_pc;
          e0_instr_n = in_instr;
        end else if (pop) begin
          state_n = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (pop) begin
          e0_pc_n    = e1_pc;
          e0_instr_n = e1_instr;
          state_n    = ST_ONE;
        end
      end
      default: state_n = ST_EMPTY;
    endcase
    // Flush wins over any simultaneous accept or pop.
    if (flush) begin
      state_n  = ST_EMPTY;
      halted_n = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_EMPTY;
      halted    <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_pc    <= '0;
      out_instr <= NOP_INSTR;
    end else begin
      state     <= state_n;
      halted    <= halted_n;
      in_ready  <= (state_n != ST_FULL) & ~halted_n;
      out_valid <= (state_n != ST_EMPTY);
      out_pc    <= (state_n != ST_EMPTY) ? e0_pc_n : '0;
      out_instr <= (state_n != ST_EMPTY) ? e0_instr_n : NOP_INSTR;
    end
  end

  // Payload needs no reset: it is only visible through the masked output registers.
  always_ff @(posedge clk) begin
    e0_pc    <= e0_pc_n;
    e0_instr <= e0_instr_n;
    e1_pc    <= e1_pc_n;
    e1_instr <= e1_instr_n;
  end

endmodule

// File: tb/tb_if_id_skid.sv
// Directed bench for if_id_skid: reset, stall/skid, streaming, flush, halt, mid-cycle reset.
module tb_if_id_skid;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, flush, out_valid, out_ready, halted;
  logic [15:0] in_pc, in_instr, out_pc, out_instr;

  int errors = 0;
  int checks = 0;

  if_id_skid #(.WIDTH(16), .NOP_INSTR(16'h0800)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] pc, input logic [15:0] instr);
    in_valid = 1'b1;
    in_pc    = pc;
    in_instr = instr;
    step();
    in_valid = 1'b0;
  endtask

  logic [15:0] words [8];
  int tx, rx;
  logic acc, pp;

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0; flush = 1'b0; out_ready = 1'b0;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_instr", out_instr, 16'h0800);
    chk("rst_out_pc",    out_pc, 0);
    chk("rst_in_ready",  in_ready, 0);
    chk("rst_halted",    halted, 0);
    rst = 1'b1;
    step();
    chk("rel_in_ready", in_ready, 1);

    // 1: single word, latency one cycle
    out_ready = 1'b1;
    send(16'h0002, 16'h4001);
    chk("t1_valid", out_valid, 1);
    chk("t1_instr", out_instr, 16'h4001);
    chk("t1_pc",    out_pc, 16'h0002);
    step();
    chk("t1_drained", out_valid, 0);
    chk("t1_nop",     out_instr, 16'h0800);

    // 2: stall fills both entries, third word held off
    out_ready = 1'b0;
    send(16'h0010, 16'h1111);
    chk("t2_ready1", in_ready, 1);
    send(16'h0012, 16'h2222);
    chk("t2_full_ready", in_ready, 0);
    in_valid = 1'b1; in_instr = 16'h3030; in_pc = 16'h0014;
    step();
    in_valid = 1'b0;
    chk("t2_held_ready", in_ready, 0);
    chk("t2_head", out_instr, 16'h1111);
    chk("t2_head_pc", out_pc, 16'h0010);
    out_ready = 1'b1;
    step();
    chk("t2_second", out_instr, 16'h2222);
    chk("t2_second_pc", out_pc, 16'h0012);
    step();
    chk("t2_empty", out_valid, 0);

    // 3: streaming with out_ready toggling
    for (int i = 0; i < 8; i++) words[i] = 16'h7100 + 16'(i);
    tx = 0; rx = 0;
    for (int cyc = 0; cyc < 60 && rx < 8; cyc++) begin
      out_ready = (cyc % 2 == 0);
      in_valid  = (tx < 8);
      in_instr  = (tx < 8) ? words[tx] : 16'h0;
      in_pc     = 16'(2 * tx + 2);
      acc = in_valid & in_ready;
      pp  = out_valid & out_ready;
      if (pp) begin
        chk("t3_order", out_instr, words[rx]);
        chk("t3_pc", out_pc, 32'(2 * rx + 2));
        rx++;
      end
      step();
      if (acc) tx++;
    end
    in_valid = 1'b0;
    chk("t3_count", rx, 8);
    out_ready = 1'b1;
    step();
    chk("t3_no_dup", out_valid, 0);

    // 4: flush while FULL with a word presented, then while ONE with a real accept
    out_ready = 1'b0;
    send(16'h0020, 16'hA1A1);
    send(16'h0022, 16'hA2A2);
    flush = 1'b1; in_valid = 1'b1; in_instr = 16'h3333; in_pc = 16'h0024;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("t4_valid", out_valid, 0);
    chk("t4_nop",   out_instr, 16'h0800);
    chk("t4_pc",    out_pc, 0);
    chk("t4_ready", in_ready, 1);
    send(16'h0030, 16'h4444);
    flush = 1'b1; in_valid = 1'b1; in_instr = 16'h3333;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("t4_discard", out_valid, 0);
    out_ready = 1'b1;
    step();
    chk("t4_never", out_valid, 0);
    chk("t4_never_instr", out_instr, 16'h0800);

    // 5: HALT blocks intake, still delivered, flush clears
    out_ready = 1'b0;
    send(16'h0040, 16'h0000);
    chk("t5_halted", halted, 1);
    chk("t5_ready",  in_ready, 0);
    chk("t5_valid",  out_valid, 1);
    chk("t5_instr",  out_instr, 16'h0000);
    chk("t5_pc",     out_pc, 16'h0040);
    in_valid = 1'b1; in_instr = 16'h5555; in_pc = 16'h0042;
    step();
    chk("t5_blocked", in_ready, 0);
    out_ready = 1'b1;
    step();
    chk("t5_drained", out_valid, 0);
    chk("t5_still_halted", halted, 1);
    step();
    chk("t5_no_5555", out_valid, 0);
    in_valid = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t5_unhalt", halted, 0);
    chk("t5_ready_back", in_ready, 1);

    // 6: asynchronous reset while FULL
    out_ready = 1'b0;
    send(16'h0050, 16'h6161);
    send(16'h0052, 16'h6262);
    chk("t6_full", in_ready, 0);
    #2 rst = 1'b0;
    #1;
    chk("t6_valid", out_valid, 0);
    chk("t6_nop",   out_instr, 16'h0800);
    chk("t6_pc",    out_pc, 0);
    chk("t6_ready", in_ready, 0);
    step();
    #2 rst = 1'b1;
    step();
    chk("t6_rel_ready", in_ready, 1);
    chk("t6_rel_valid", out_valid, 0);
    out_ready = 1'b1;
    send(16'h0060, 16'h7777);
    chk("t6_resume", out_instr, 16'h7777);
    chk("t6_resume_pc", out_pc, 16'h0060);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
